// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency instruction memory,
// and fills IF/ID through a one-entry skid buffer. Optional macro: FETCH_STALL_CNT_EN.
module if_fetch_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(32'h0000_0013)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            PC_Stall,
  input  logic            IF_ID_Stall,
  input  logic            IF_ID_Flush,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  input  logic [XLEN-1:0] Imem_Data,
  output logic [XLEN-1:0] Imem_Addr,
  output logic            Imem_Rd_En,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PC_Plus4,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     Stall_Cycles
`endif
);

  logic            stall_pc;
  logic            redirect;
  logic [XLEN-1:0] cur_instr;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            f1_valid_q, f1_valid_d;
  logic [XLEN-1:0] f1_pc_q, f1_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;

  // A blocked IF/ID also freezes the PC so no fetch can overrun it.
  assign stall_pc   = PC_Stall | IF_ID_Stall;
  assign redirect   = Branch_Taken;
  assign Imem_Rd_En = !rst && !stall_pc && !redirect;
  assign Imem_Addr  = pc_q;
  assign cur_instr  = skid_valid_q ? skid_instr_q : Imem_Data;

  always_comb begin
    pc_d         = pc_q;
    f1_valid_d   = f1_valid_q;
    f1_pc_d      = f1_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;

    if (redirect)       pc_d = Branch_Target & ~XLEN'(3);
    else if (!stall_pc) pc_d = pc_q + XLEN'(4);

    if (redirect) begin
      f1_valid_d = 1'b0;
    end else if (Imem_Rd_En) begin
      f1_valid_d = 1'b1;
      f1_pc_d    = pc_q;
    end else if (!IF_ID_Stall) begin
      f1_valid_d = 1'b0;
    end

    // Memory data is only valid for one cycle, so catch it on the first stalled cycle.
    if (redirect) begin
      skid_valid_d = 1'b0;
    end else if (f1_valid_q && IF_ID_Stall && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_instr_d = Imem_Data;
    end else if (!IF_ID_Stall) begin
      skid_valid_d = 1'b0;
    end

    if (IF_ID_Flush || redirect) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!IF_ID_Stall) begin
      ifid_valid_d = f1_valid_q;
      ifid_instr_d = f1_valid_q ? cur_instr : NOP_INSTR;
      ifid_pc_d    = f1_pc_q;
      ifid_pc4_d   = f1_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      f1_valid_q   <= 1'b0;
      f1_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= XLEN'(4);
    end else begin
      pc_q         <= pc_d;
      f1_valid_q   <= f1_valid_d;
      f1_pc_q      <= f1_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign IF_ID_Valid    = ifid_valid_q;
  assign IF_ID_Instr    = ifid_instr_q;
  assign IF_ID_PC       = ifid_pc_q;
  assign IF_ID_PC_Plus4 = ifid_pc4_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (IF_ID_Stall && ifid_valid_q && !IF_ID_Flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory returns addr|1; reference model tracks fetches by address.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        PC_Stall = 1'b0, IF_ID_Stall = 1'b0, IF_ID_Flush = 1'b0, Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = '0, Imem_Data = '0;
  logic [31:0] Imem_Addr, IF_ID_PC, IF_ID_PC_Plus4, IF_ID_Instr;
  logic        Imem_Rd_En, IF_ID_Valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] Stall_Cycles;
`endif

  if_fetch_stage dut (
    .CLK(CLK), .rst(rst), .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall),
    .IF_ID_Flush(IF_ID_Flush), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Imem_Data(Imem_Data), .Imem_Addr(Imem_Addr), .Imem_Rd_En(Imem_Rd_En),
    .IF_ID_PC(IF_ID_PC), .IF_ID_PC_Plus4(IF_ID_PC_Plus4), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid)
`ifdef FETCH_STALL_CNT_EN
    , .Stall_Cycles(Stall_Cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit rnd_garbage = 1'b0;

  // Reference model: the fetched word is always mem[pc] = pc|1, whatever the stall history.
  logic [31:0] m_pc;
  logic        m_fv;
  logic [31:0] m_fpc;
  logic        m_fpc_known;
  logic        m_v;
  logic [31:0] m_instr, m_ipc, m_ipc4;
  logic        m_ipc_known;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ps, input logic is, input logic fl,
                      input logic bt, input logic [31:0] tgt);
    logic        rd;
    logic [31:0] a;
    logic        exp_rd;
    rst = r; PC_Stall = ps; IF_ID_Stall = is; IF_ID_Flush = fl;
    Branch_Taken = bt; Branch_Target = tgt;
    #1;
    exp_rd = !r && !(ps || is) && !bt;
    chk("rd_en", {31'd0, Imem_Rd_En}, {31'd0, exp_rd});
    if (!r) chk("imem_addr", Imem_Addr, m_pc);
    rd = Imem_Rd_En;
    a  = Imem_Addr;
    if (r) begin
      m_pc = 32'h0; m_fv = 1'b0; m_fpc_known = 1'b0;
      m_v = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h4; m_ipc_known = 1'b1;
      m_cnt = 32'h0;
    end else begin
      if (is && m_v && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (fl || bt) begin
        m_v = 1'b0; m_instr = NOP;
      end else if (!is) begin
        m_v = m_fv;
        m_instr = m_fv ? (m_fpc | 32'h1) : NOP;
        m_ipc = m_fpc; m_ipc4 = m_fpc + 32'h4; m_ipc_known = m_fpc_known;
      end
      if (bt) m_fv = 1'b0;
      else if (exp_rd) begin m_fv = 1'b1; m_fpc = m_pc; m_fpc_known = 1'b1; end
      else if (!is) m_fv = 1'b0;
      if (bt) m_pc = {tgt[31:2], 2'b00};
      else if (!(ps || is)) m_pc = m_pc + 32'h4;
    end
    @(posedge CLK);
    #1;
    Imem_Data = rd ? (a | 32'h1) : (rnd_garbage ? $urandom : 32'hDEAD_BEEF);
    chk("ifid_valid", {31'd0, IF_ID_Valid}, {31'd0, m_v});
    chk("ifid_instr", IF_ID_Instr, m_instr);
    if (m_ipc_known) begin
      chk("ifid_pc", IF_ID_PC, m_ipc);
      chk("ifid_pc4", IF_ID_PC_Plus4, m_ipc4);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cycles", Stall_Cycles, m_cnt);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_fv = 1'b0; m_fpc = 32'h0; m_fpc_known = 1'b0; m_v = 1'b0;
    m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h4; m_ipc_known = 1'b0; m_cnt = 32'h0;

    // Reset, then first instruction on the 2nd edge, then sequential PCs.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rst_instr", IF_ID_Instr, NOP);
    chk("rst_pc4", IF_ID_PC_Plus4, 32'h4);
    run(1);
    chk("t1_not_yet", {31'd0, IF_ID_Valid}, 32'd0);
    run(1);
    chk("t1_first_pc", IF_ID_PC, 32'h0);
    chk("t1_first_instr", IF_ID_Instr, 32'h1);
    run(1);
    chk("t1_second_pc", IF_ID_PC, 32'h4);

    // Three stall cycles with 0x8 in flight; the skid buffer must keep word 0x9.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    chk("t2_hold_pc", IF_ID_PC, 32'h4);
    run(1);
    chk("t2_skid_pc", IF_ID_PC, 32'h8);
    chk("t2_skid_instr", IF_ID_Instr, 32'h9);

    // Redirect with a fetch in flight.
    step(0, 0, 0, 0, 1, 32'h100);
    chk("t3_bubble_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("t3_bubble_instr", IF_ID_Instr, NOP);
    chk("t3_target_addr", Imem_Addr, 32'h100);
    run(2);
    chk("t3_target_pc", IF_ID_PC, 32'h100);
    chk("t3_target_instr", IF_ID_Instr, 32'h101);

    // Misaligned target is word-aligned; flush beats a simultaneous stall.
    step(0, 0, 0, 0, 1, 32'h203);
    chk("t4_aligned", Imem_Addr, 32'h200);
    run(3);
    step(0, 0, 1, 1, 0, 0);
    chk("t4_flush_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("t4_flush_instr", IF_ID_Instr, NOP);
    run(3);

    // PC wrap-around at the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    run(3);
    chk("wrap_pc", IF_ID_PC, 32'h0);

    // Reset in the middle of a stall with the skid buffer loaded.
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("t5_rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("t5_rst_instr", IF_ID_Instr, NOP);
    chk("t5_rst_pc", IF_ID_PC, 32'h0);
    run(2);
    chk("t5_restart_pc", IF_ID_PC, 32'h0);

`ifdef FETCH_STALL_CNT_EN
    step(1, 0, 0, 0, 0, 0);
    run(3);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    chk("t6_cnt5", Stall_Cycles, 32'd5);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    chk("t6_saturate", Stall_Cycles, 32'hFFFF_FFFF);
    step(1, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic against the model.
    rnd_garbage = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 8), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
